// File: rtl/song_pkg.sv
// Shared widths, ROM entry field bounds and FSM state type for the song sequencer.
package song_pkg;

    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int ADDR_W = SONG_W + IDX_W;
    localparam int ROM_W  = 16;

    localparam int NOTE_HI = 11;
    localparam int NOTE_LO = 6;
    localparam int DUR_HI  = 5;
    localparam int DUR_LO  = 0;

    localparam logic [DUR_W-1:0] END_DUR  = '0;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RDWAIT,
        PLAY
    } state_t;

endpackage

// File: rtl/song_reader_if.sv
// Control, ROM bus and note-player signals of song_reader; master is the reader side.
interface song_reader_if;
    import song_pkg::*;

    logic                  play;
    logic [SONG_W-1:0]     song;
    logic                  beat;
    logic [ROM_W-1:0]      rom_dout;
    logic [ADDR_W-1:0]     rom_addr;
    logic [NOTE_W-1:0]     note;
    logic                  note_start;
    logic                  song_done;
    logic                  busy;

    modport master (
        input  play, song, beat, rom_dout,
        output rom_addr, note, note_start, song_done, busy
    );

    modport slave (
        output play, song, beat, rom_dout,
        input  rom_addr, note, note_start, song_done, busy
    );

endinterface

// File: rtl/song_reader_dur_counter.sv
// Loadable beat down-counter; last flags the final beat of the current note.
module dur_counter
    import song_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [DUR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - DUR_W'(1);
        end
    end

    assign last = (cnt == DUR_W'(1));

endmodule

// File: rtl/song_reader.sv
// Song ROM sequencer: walks {song, idx} entries and holds each note for its beat count.
// Define SONG_READER_LOOP_EN to restart the song at entry 0 instead of returning to IDLE.
module song_reader
    import song_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    song_reader_if.master bus
);

    state_t            state;
    logic              play_q;
    logic [SONG_W-1:0] song_q;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] note_q;
    logic              note_start;
    logic              song_done;
    logic              busy;

    logic [DUR_W-1:0]  dur;
    logic [NOTE_W-1:0] nt;
    logic              play_rise;
    logic              cnt_load;
    logic              cnt_en;
    logic              last_beat;
    logic              end_song;
    logic              unused_hi;

    assign dur       = bus.rom_dout[DUR_HI:DUR_LO];
    assign nt        = bus.rom_dout[NOTE_HI:NOTE_LO];
    assign unused_hi = ^bus.rom_dout[ROM_W-1:NOTE_HI+1];
    assign play_rise = bus.play && !play_q;
    assign cnt_load  = (state == RDWAIT) && (dur != END_DUR);
    // Pause gates the beat, so a beat coinciding with play falling is not counted.
    assign cnt_en    = (state == PLAY) && bus.beat && bus.play;
    assign end_song  = ((state == RDWAIT) && (dur == END_DUR)) ||
                       (cnt_en && last_beat && (idx == LAST_IDX));

    dur_counter u_dur (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (dur),
        .en       (cnt_en),
        .last     (last_beat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            play_q     <= 1'b0;
            song_q     <= '0;
            idx        <= '0;
            rom_addr   <= '0;
            note_q     <= '0;
            note_start <= 1'b0;
            song_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            play_q     <= bus.play;
            note_start <= 1'b0;
            song_done  <= 1'b0;
            if (end_song) begin
                song_done <= 1'b1;
                note_q    <= '0;
`ifdef SONG_READER_LOOP_EN
                idx       <= '0;
                rom_addr  <= {song_q, IDX_W'(0)};
                state     <= FETCH;
`else
                busy      <= 1'b0;
                state     <= IDLE;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (play_rise) begin
                            song_q   <= bus.song;
                            idx      <= '0;
                            rom_addr <= {bus.song, IDX_W'(0)};
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: state <= RDWAIT;
                    RDWAIT: begin
                        note_q     <= nt;
                        note_start <= 1'b1;
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (cnt_en && last_beat) begin
                            idx      <= idx + IDX_W'(1);
                            rom_addr <= {song_q, idx + IDX_W'(1)};
                            state    <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rom_addr   = rom_addr;
    assign bus.note       = bus.play ? note_q : '0;
    assign bus.note_start = note_start;
    assign bus.song_done  = song_done;
    assign bus.busy       = busy;

endmodule
